// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, zero-skew sync/blank strobes,
// cocktail-mode address mirroring and a line-compare raster interrupt.
module video_timing_gen #(
  parameter int H_TOTAL  = 256,
  parameter int H_ACTIVE = 192,
  parameter int HS_START = 208,
  parameter int HS_END   = 224,
  parameter int V_TOTAL  = 260,
  parameter int V_ACTIVE = 240,
  parameter int VS_START = 248,
  parameter int VS_END   = 252,
  parameter int HW       = 9,
  parameter int VW       = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          flip,
  input  logic [VW-1:0] irq_line,
  input  logic          irq_ack,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic [HW-1:0] addr_x,
  output logic [VW-1:0] addr_y,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          line_start,
  output logic          frame_start,
  output logic          irq
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] X_MAX  = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] Y_MAX  = VW'(V_ACTIVE - 1);

  localparam logic [HW:0] H_ACT_W = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_S_W  = (HW+1)'(HS_START);
  localparam logic [HW:0] HS_E_W  = (HW+1)'(HS_END);
  localparam logic [VW:0] V_ACT_W = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_S_W  = (VW+1)'(VS_START);
  localparam logic [VW:0] VS_E_W  = (VW+1)'(VS_END);
  localparam logic [VW:0] V_TOT_W = (VW+1)'(V_TOTAL);

  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic [HW:0]   h_ext;
  logic [VW:0]   v_ext;
  logic          h_wrap;
  logic          v_wrap;
  logic          line_evt;
  logic          frame_evt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          bl_nxt;
  logic          irq_hit;
  logic [VW-1:0] cmp;
  logic          flip_q;

  always_comb begin
    h_wrap    = (hcount == H_LAST);
    v_wrap    = (vcount == V_LAST);
    h_nxt     = hcount;
    v_nxt     = vcount;
    line_evt  = clk_en && h_wrap;
    frame_evt = line_evt && v_wrap;
    if (clk_en) begin
      h_nxt = h_wrap ? '0 : hcount + 1'b1;
      if (h_wrap) begin
        v_nxt = v_wrap ? '0 : vcount + 1'b1;
      end
    end
  end

  // Strobes are decoded from the next counter values so that the
  // registered outputs line up with hcount/vcount on the same edge.
  always_comb begin
    h_ext  = {1'b0, h_nxt};
    v_ext  = {1'b0, v_nxt};
    hs_nxt = (h_ext >= HS_S_W) && (h_ext < HS_E_W);
    vs_nxt = (v_ext >= VS_S_W) && (v_ext < VS_E_W);
    bl_nxt = (h_ext >= H_ACT_W) || (v_ext >= V_ACT_W);
  end

  // Compare value is the one latched at the previous line start;
  // out-of-range values can never match.
  always_comb begin
    irq_hit = line_evt
           && (v_nxt == cmp)
           && ({1'b0, cmp} < V_TOT_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      cmp         <= '1;
      flip_q      <= 1'b0;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      blank       <= bl_nxt;
      line_start  <= line_evt;
      frame_start <= frame_evt;
      if (line_evt) begin
        cmp <= irq_line;
      end
      if (frame_evt) begin
        flip_q <= flip;
      end
    end
  end

  // Set beats acknowledge; acknowledge works regardless of clk_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (irq_hit) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end

  always_comb begin
    addr_x = flip_q ? (X_MAX - hcount) : hcount;
    addr_y = flip_q ? (Y_MAX - vcount) : vcount;
  end

endmodule
